// File: rtl/io_event_fifo.sv
// Turns debounced button press edges and switch changes into 14-bit event words
// and buffers them in a first-word-fall-through FIFO for the polling CPU.
module io_event_fifo #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [4:0]    button,
    input  logic [7:0]    SW,
    input  logic          rd_en,
    input  logic          clr_ovf,
    output logic [13:0]   rd_data,
    output logic          ev_valid,
    output logic [AW:0]   ev_count,
    output logic          overflow,
    output logic [4:0]    btn_level,
    output logic [7:0]    sw_level
);

    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];
    localparam logic [AW:0] CNT_ONE  = {{AW{1'b0}}, 1'b1};

    logic [4:0]    btn_prev;
    logic [7:0]    sw_prev;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [13:0]   mem [DEPTH];

    logic [4:0]    press;
    logic          sw_chg;
    logic          event_hit;
    logic          empty;
    logic          full;
    logic          do_push;
    logic          do_pop;
    logic          drop;

    // Handshake: ev_valid means rd_data holds the oldest event; the CPU takes it by
    // holding rd_en high across a rising edge. rd_en while ev_valid is low is ignored.
    always_comb begin
        press     = button & ~btn_prev;
        sw_chg    = (SW != sw_prev);
        event_hit = (press != 5'd0) | sw_chg;
        empty     = (ev_count == '0);
        full      = (ev_count == FULL_CNT);
        do_pop    = rd_en & ~empty;
        // A pop in the same cycle frees a slot, so a full FIFO still accepts the push.
        do_push   = event_hit & (~full | do_pop);
        drop      = event_hit & full & ~do_pop;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_prev  <= '0;
            sw_prev   <= '0;
            btn_level <= '0;
            sw_level  <= '0;
        end else begin
            btn_prev  <= button;
            sw_prev   <= SW;
            btn_level <= button;
            sw_level  <= SW;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            ev_count <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   ev_count <= ev_count + CNT_ONE;
                2'b01:   ev_count <= ev_count - CNT_ONE;
                default: ev_count <= ev_count;
            endcase
        end
    end

    // Setting wins over clearing when a drop and clr_ovf land on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (clr_ovf) begin
            overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= {sw_chg, press, SW};
    end

    always_comb begin
        ev_valid = ~empty;
        rd_data  = empty ? 14'd0 : mem[rd_ptr];
    end

endmodule

// File: tb/tb_io_event_fifo.sv
// Directed bench for io_event_fifo: expected event words are queued as stimulus
// is driven and compared against rd_data as each entry is popped.
module tb_io_event_fifo;

    logic        clk;
    logic        rst;
    logic [4:0]  button;
    logic [7:0]  sw;
    logic        rd_en;
    logic        clr_ovf;
    logic [13:0] rd_data;
    logic        ev_valid;
    logic [3:0]  ev_count;
    logic        overflow;
    logic [4:0]  btn_level;
    logic [7:0]  sw_level;

    logic [13:0] exp_q[$];
    int total;
    int bad;

    io_event_fifo #(.DEPTH(8), .AW(3)) dut (
        .clk(clk),
        .rst(rst),
        .button(button),
        .SW(sw),
        .rd_en(rd_en),
        .clr_ovf(clr_ovf),
        .rd_data(rd_data),
        .ev_valid(ev_valid),
        .ev_count(ev_count),
        .overflow(overflow),
        .btn_level(btn_level),
        .sw_level(sw_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 ns after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic pop_check(input string tag);
        logic [13:0] e;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $error("FAIL %s observed=%0h expected=<queue empty>", tag, rd_data);
        end else begin
            e = exp_q.pop_front();
            chk(tag, {2'b0, rd_data}, {2'b0, e});
        end
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
    endtask

    task automatic press_release(input logic [4:0] b);
        button = b;
        tick();
        button = 5'd0;
        tick();
    endtask

    initial begin
        logic [4:0] b;
        total   = 0;
        bad     = 0;
        rst     = 1'b1;
        button  = 5'd0;
        sw      = 8'd0;
        rd_en   = 1'b0;
        clr_ovf = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        repeat (5) tick();
        chk("reset_valid", {15'd0, ev_valid}, 16'd0);
        chk("reset_count", {12'd0, ev_count}, 16'd0);
        chk("reset_ovf",   {15'd0, overflow}, 16'd0);
        chk("reset_data",  {2'd0, rd_data},   16'd0);

        // Single press, hold, then release: exactly one event.
        button = 5'b00100;
        exp_q.push_back(14'b0_00100_00000000);
        tick();
        chk("press_count", {12'd0, ev_count}, 16'd1);
        chk("press_valid", {15'd0, ev_valid}, 16'd1);
        chk("btn_level",   {11'd0, btn_level}, 16'h0004);
        tick();
        button = 5'd0;
        tick();
        chk("hold_release_count", {12'd0, ev_count}, 16'd1);
        pop_check("press_word");
        chk("pop_empty_valid", {15'd0, ev_valid}, 16'd0);
        chk("pop_empty_data",  {2'd0, rd_data},   16'd0);

        // Switch change and button press in the same cycle.
        button = 5'b00001;
        sw     = 8'hA5;
        exp_q.push_back(14'b1_00001_10100101);
        tick();
        chk("combo_count", {12'd0, ev_count}, 16'd1);
        chk("sw_level",    {8'd0, sw_level},  16'h00A5);
        pop_check("combo_word");
        chk("combo_pop_valid", {15'd0, ev_valid}, 16'd0);
        button = 5'd0;
        tick();

        // rd_en while empty is ignored.
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk("underflow_count", {12'd0, ev_count}, 16'd0);

        // Eight presses fill the FIFO; a ninth is dropped.
        for (int i = 0; i < 8; i++) begin
            b = 5'b00001 << (i % 5);
            exp_q.push_back({1'b0, b, 8'hA5});
            press_release(b);
        end
        chk("full_count_pre", {12'd0, ev_count}, 16'd8);
        chk("full_ovf_pre",   {15'd0, overflow}, 16'd0);
        press_release(5'b11111);
        chk("full_count", {12'd0, ev_count}, 16'd8);
        chk("full_ovf",   {15'd0, overflow}, 16'd1);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        chk("clr_ovf", {15'd0, overflow}, 16'd0);

        // Full FIFO: pop and push on the same edge.
        chk("full_pop_head", {2'd0, rd_data}, {2'd0, exp_q[0]});
        void'(exp_q.pop_front());
        exp_q.push_back(14'b0_10000_10100101);
        rd_en  = 1'b1;
        button = 5'b10000;
        tick();
        rd_en  = 1'b0;
        button = 5'd0;
        chk("full_pushpop_count", {12'd0, ev_count}, 16'd8);
        chk("full_pushpop_ovf",   {15'd0, overflow}, 16'd0);
        tick();

        // Drop coinciding with clr_ovf: set wins.
        button  = 5'b01000;
        clr_ovf = 1'b1;
        tick();
        button  = 5'd0;
        clr_ovf = 1'b0;
        chk("drop_clr_ovf",   {15'd0, overflow}, 16'd1);
        chk("drop_clr_count", {12'd0, ev_count}, 16'd8);
        tick();
        for (int i = 0; i < 8; i++) pop_check($sformatf("drain_%0d", i));
        chk("drain_count", {12'd0, ev_count}, 16'd0);
        chk("drain_valid", {15'd0, ev_valid}, 16'd0);

        // Reset mid-stream with three events queued and SW=0x0F held.
        sw = 8'h0F;
        exp_q.push_back(14'b1_00001_00001111);
        press_release(5'b00001);
        press_release(5'b00010);
        press_release(5'b00100);
        chk("pre_rst_count", {12'd0, ev_count}, 16'd3);
        #1;
        rst = 1'b1;
        #1;
        chk("rst_async_count", {12'd0, ev_count}, 16'd0);
        chk("rst_async_valid", {15'd0, ev_valid}, 16'd0);
        chk("rst_async_data",  {2'd0, rd_data},   16'd0);
        chk("rst_async_sw",    {8'd0, sw_level},  16'd0);
        exp_q.delete();
        tick();
        rst = 1'b0;
        exp_q.push_back(14'b1_00000_00001111);
        tick();
        chk("post_rst_count", {12'd0, ev_count}, 16'd1);
        pop_check("post_rst_word");
        chk("post_rst_empty", {12'd0, ev_count}, 16'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/io_event_fifo.md
Name: io_event_fifo

Overview:
- Sits directly downstream of the button/switch debouncer in the IO polling path.
- Consumes the debounced 5-bit button and 8-bit switch vectors.
- Turns button press edges and switch changes into timestamp-free event words.
- Buffers the events in a small FIFO so the polling CPU cannot miss a press between polls.

Parameters:
DEPTH, 8, number of event entries; must be a power of 2, minimum 2
AW, 3, pointer width; must equal log2(DEPTH)

Ports:
clk  input  1  system clock; all state changes on the rising edge
rst  input  1  asynchronous, active-high reset
button  input  5  debounced button levels from the debouncer
SW  input  8  debounced switch levels from the debouncer
rd_en  input  1  CPU pop strobe; one entry popped per cycle while high and FIFO not empty
clr_ovf  input  1  clears the sticky overflow flag
rd_data  output  14  head event word (first-word-fall-through); {sw_chg, press[4:0], sw[7:0]}
ev_valid  output  1  high when FIFO not empty
ev_count  output  AW+1  number of stored events, 0..DEPTH
overflow  output  1  sticky; an event was dropped because the FIFO was full
btn_level  output  5  registered copy of button
sw_level  output  8  registered copy of SW

Behaviour:
- Reset (async, rst=1):
  - btn_prev=0, sw_prev=0, btn_level=0, sw_level=0.
  - Read and write pointers = 0; ev_count=0, ev_valid=0, overflow=0.
  - rd_data = 0 while empty.
  - FIFO memory contents are don't-care.
- Edge detect, combinational against the registered previous values:
  - press = button & ~btn_prev
  - sw_chg = (SW != sw_prev)
  - event = (press != 0) | sw_chg
  - Releases (falling edges) alone generate no event.
- Every edge: btn_prev<=button, sw_prev<=SW, btn_level<=button, sw_level<=SW.
- Push:
  - If event is true at edge k, word {sw_chg, press, SW} is written at edge k.
  - ev_valid rises after edge k, i.e. 1-cycle latency from sampled input change.
  - Multiple buttons pressed in the same cycle produce one event with multiple press bits set.
- Pop:
  - If rd_en=1 and ev_count!=0 at an edge, the read pointer advances.
  - rd_data always shows the entry at the read pointer; it shows 0 when empty.
  - rd_en while empty is ignored; no underflow, no state change.
- Simultaneous push and pop:
  - Not empty (including full): both occur, ev_count unchanged.
  - Empty: push only; no bypass, and the new entry is visible the next cycle.
- Full (ev_count==DEPTH):
  - A push without a simultaneous pop is dropped and overflow<=1.
  - Stored contents and pointers are unchanged.
- overflow:
  - Cleared by clr_ovf=1 at an edge.
  - If a drop and clr_ovf coincide, set wins (overflow=1).
- Pointers are AW bits and wrap modulo DEPTH.
- ev_count is tracked as an AW+1-bit counter: +1 on push only, -1 on pop only.
- Reset asserted mid-operation:
  - Immediately empties the FIFO and clears overflow and all history.
  - After release, inputs already high register as press or change events on the first edge, because the prev registers are 0.
- Inputs are assumed synchronous to clk; the debouncer output is registered, so no synchronizer is needed.

Test Plan:
- Reset release with button=0, SW=0 held; wait 5 cycles -> ev_valid=0, ev_count=0, overflow=0, rd_data=0.
- Raise button=5'b00100 for one cycle, then hold -> exactly one event; rd_data=14'b0_00100_00000000; ev_count=1. Later release -> no new event.
- Change SW from 0x00 to 0xA5 while button=5'b00001 rises in the same cycle -> one event, rd_data=14'b1_00001_10100101. Pulse rd_en -> ev_valid=0 next cycle.
- Generate 9 separate presses with DEPTH=8, no reads -> ev_count=8, overflow=1. Popping 8 returns events 1..8 in order; the 9th is lost.
- Full FIFO with rd_en=1 and a new press in the same cycle -> ev_count stays 8, overflow stays 0, and the new event appears last. Then clr_ovf together with a drop -> overflow remains 1.
- rst pulse mid-stream with 3 events queued and SW=0x0F held -> ev_count=0 immediately. First edge after release pushes {1, 00000, 0x0F}.
